// File: rtl/game_pkg.sv
// Shared types and sizes for the game flow controller and its frame timer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        LOST  = 3'd3,
        OVER  = 3'd4
    } state_e;

    localparam int unsigned LIVES_DEF = 3;
    localparam int unsigned SCORE_W   = 8;
    localparam int unsigned CNT_W     = 8;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Signals exchanged between the flow controller (master) and the game core (slave).
interface game_flow_ctrl_if;
    logic       frame_tick;
    logic       ball_lost;
    logic       brick_hit;
    logic       core_rst;
    logic       core_run;
    logic [1:0] bar_sel;

    modport master (
        input  frame_tick, ball_lost, brick_hit,
        output core_rst, core_run, bar_sel
    );

    modport slave (
        output frame_tick, ball_lost, brick_hit,
        input  core_rst, core_run, bar_sel
    );
endinterface

// File: rtl/game_frame_timer.sv
// Frame-tick counter with synchronous clear; done fires on the tick that reaches term.
module game_frame_timer
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    // Combinational so the owner can change state on the very tick that hits term.
    assign done = tick && !clear && (cnt_inc == term);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencing: start, serve delay, play, life loss, game-over hold.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES        = LIVES_DEF,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned OVER_FRAMES  = 180
) (
    input  logic               clk,
    input  logic               reset,
    game_flow_ctrl_if.master   core,
    input  logic               start_btn,
    input  logic [1:0]         level_sw,
    output logic [1:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic               game_over,
    output logic [2:0]         state
);

    localparam logic [CNT_W-1:0] SERVE_TERM = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] OVER_TERM  = CNT_W'(OVER_FRAMES);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);

    state_e             state_q, state_d;
    logic               arm_q, arm_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         bar_q, bar_d;
    logic               core_rst_q, core_rst_d;
    logic               core_run_q, core_run_d;
    logic               over_q, over_d;

    logic               start_edge;
    logic               tmr_clear;
    logic               tmr_done;
    logic [CNT_W-1:0]   tmr_term;

    // arm_q holds "button was low last cycle" and resets low, so a button
    // held through reset release cannot be mistaken for a fresh press.
    assign arm_d      = ~start_btn;
    assign start_edge = start_btn & arm_q;

    assign tmr_term  = (state_q == OVER) ? OVER_TERM : SERVE_TERM;

    game_frame_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clear),
        .tick  (core.frame_tick),
        .term  (tmr_term),
        .done  (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        bar_d     = bar_q;
        tmr_clear = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = SERVE;
                    lives_d = LIVES_INIT;
                    score_d = '0;
                    bar_d   = level_sw;
                end
            end
            SERVE: begin
                tmr_clear = 1'b0;
                if (tmr_done) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (core.brick_hit) begin
                    score_d = sat_inc(score_q);
                end
                if (core.ball_lost) begin
                    state_d = LOST;
                end
            end
            LOST: begin
                lives_d = lives_q - 2'd1;
                state_d = (lives_q == 2'd1) ? OVER : SERVE;
            end
            OVER: begin
                tmr_clear = 1'b0;
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs decoded from the next state so they are valid in a state's first cycle.
        core_rst_d = (state_d == IDLE) || (state_d == LOST);
        core_run_d = (state_d == PLAY);
        over_d     = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            arm_q      <= 1'b0;
            lives_q    <= '0;
            score_q    <= '0;
            bar_q      <= '0;
            core_rst_q <= 1'b1;
            core_run_q <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            bar_q      <= bar_d;
            core_rst_q <= core_rst_d;
            core_run_q <= core_run_d;
            over_q     <= over_d;
        end
    end

    assign core.core_rst = core_rst_q;
    assign core.core_run = core_run_q;
    assign core.bar_sel  = bar_q;
    assign lives         = lives_q;
    assign score         = score_q;
    assign game_over     = over_q;
    assign state         = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: expectations queued with stimulus, drained after the edge.
module tb_game_flow_ctrl;
    import game_pkg::*;

    logic       clk;
    logic       reset;
    logic       start_btn;
    logic [1:0] level_sw;
    logic [1:0] lives;
    logic [7:0] score;
    logic       game_over;
    logic [2:0] state;

    game_flow_ctrl_if cif();

    game_flow_ctrl #(
        .LIVES        (3),
        .SERVE_FRAMES (60),
        .OVER_FRAMES  (180)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core      (cif.master),
        .start_btn (start_btn),
        .level_sw  (level_sw),
        .lives     (lives),
        .score     (score),
        .game_over (game_over),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {SIG_STATE, SIG_RST, SIG_RUN, SIG_BAR, SIG_LIVES, SIG_SCORE, SIG_OVER} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        int unsigned exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned observe(input sig_e s);
        case (s)
            SIG_STATE: return int'(state);
            SIG_RST:   return int'(cif.core_rst);
            SIG_RUN:   return int'(cif.core_run);
            SIG_BAR:   return int'(cif.bar_sel);
            SIG_LIVES: return int'(lives);
            SIG_SCORE: return int'(score);
            default:   return int'(game_over);
        endcase
    endfunction

    task automatic push(input string tag, input sig_e s, input int unsigned v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic expect_all(input string tag, input int unsigned st, input int unsigned rst,
                              input int unsigned run, input int unsigned bar, input int unsigned lv,
                              input int unsigned sc, input int unsigned go);
        push({tag, ".state"}, SIG_STATE, st);
        push({tag, ".core_rst"}, SIG_RST, rst);
        push({tag, ".core_run"}, SIG_RUN, run);
        push({tag, ".bar_sel"}, SIG_BAR, bar);
        push({tag, ".lives"}, SIG_LIVES, lv);
        push({tag, ".score"}, SIG_SCORE, sc);
        push({tag, ".game_over"}, SIG_OVER, go);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        cif.frame_tick = 1'b1;
        step();
        cif.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            pulse_tick();
            step();
        end
    endtask

    task automatic hits(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cif.brick_hit = 1'b1;
            step();
            cif.brick_hit = 1'b0;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        start_btn      = 1'b0;
        level_sw       = 2'd0;
        cif.frame_tick = 1'b0;
        cif.ball_lost  = 1'b0;
        cif.brick_hit  = 1'b0;
        #1 reset = 1'b0;

        expect_all("reset", 0, 1, 0, 0, 0, 0, 0);
        step();
        step();
        drain();
        reset = 1'b1;
        step();

        // Game 1 start with level 2, then move the switch mid-game.
        level_sw  = 2'd2;
        start_btn = 1'b1;
        expect_all("start", 1, 0, 0, 2, 3, 0, 0);
        step();
        drain();
        start_btn = 1'b0;
        level_sw  = 2'd1;

        ticks(59);
        expect_all("serve59", 1, 0, 0, 2, 3, 0, 0);
        drain();
        expect_all("serve60", 2, 0, 1, 2, 3, 0, 0);
        pulse_tick();
        drain();

        start_btn = 1'b1;
        expect_all("start_in_play", 2, 0, 1, 2, 3, 0, 0);
        step();
        drain();
        start_btn = 1'b0;
        step();

        hits(3);
        push("hits3", SIG_SCORE, 3);
        drain();

        cif.ball_lost = 1'b1;
        cif.brick_hit = 1'b1;
        expect_all("lost_hit", 3, 1, 0, 2, 3, 4, 0);
        step();
        cif.ball_lost = 1'b0;
        cif.brick_hit = 1'b0;
        drain();
        expect_all("after_lost1", 1, 0, 0, 2, 2, 4, 0);
        step();
        drain();

        cif.brick_hit = 1'b1;
        cif.ball_lost = 1'b1;
        expect_all("ignore_serve", 1, 0, 0, 2, 2, 4, 0);
        step();
        cif.brick_hit = 1'b0;
        cif.ball_lost = 1'b0;
        step();
        drain();

        ticks(59);
        expect_all("serve2", 2, 0, 1, 2, 2, 4, 0);
        pulse_tick();
        drain();

        hits(250);
        push("hits254", SIG_SCORE, 254);
        drain();
        hits(50);
        push("hits_sat", SIG_SCORE, 255);
        drain();

        cif.ball_lost = 1'b1;
        expect_all("lost2", 3, 1, 0, 2, 2, 255, 0);
        step();
        cif.ball_lost = 1'b0;
        drain();
        expect_all("after_lost2", 1, 0, 0, 2, 1, 255, 0);
        step();
        drain();

        ticks(59);
        expect_all("serve3", 2, 0, 1, 2, 1, 255, 0);
        pulse_tick();
        drain();

        cif.ball_lost = 1'b1;
        expect_all("lost3", 3, 1, 0, 2, 1, 255, 0);
        step();
        cif.ball_lost = 1'b0;
        drain();
        expect_all("over", 4, 0, 0, 2, 0, 255, 1);
        step();
        drain();

        ticks(179);
        expect_all("over179", 4, 0, 0, 2, 0, 255, 1);
        drain();
        expect_all("over_done", 0, 1, 0, 2, 0, 255, 0);
        pulse_tick();
        drain();

        // Game 2 picks up the switch value changed during game 1.
        start_btn = 1'b1;
        expect_all("start2", 1, 0, 0, 1, 3, 0, 0);
        step();
        drain();
        start_btn = 1'b0;
        ticks(59);
        expect_all("serve_g2", 2, 0, 1, 1, 3, 0, 0);
        pulse_tick();
        drain();
        hits(1);
        push("hit_g2", SIG_SCORE, 1);
        drain();

        // Reset mid-play with the button held through release.
        start_btn = 1'b1;
        reset     = 1'b0;
        expect_all("async_rst", 0, 1, 0, 0, 0, 0, 0);
        #2;
        drain();
        step();
        reset = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            step();
        end
        expect_all("held_btn", 0, 1, 0, 0, 0, 0, 0);
        drain();
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        expect_all("restart", 1, 0, 0, 1, 3, 0, 0);
        step();
        drain();
        start_btn = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3: lives loaded at game start, range 1..3.
REQ-002 SHALL have parameter SERVE_FRAMES, default 60: frame ticks the ball is held before each serve, range 1..255.
REQ-003 SHALL have parameter OVER_FRAMES, default 180: frame ticks the game-over screen is held, range 1..255.
REQ-004 SHALL have port clk  in  1  system/pixel clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port frame_tick  in  1  one-cycle pulse per video frame, issued at the same point as the core's refresh tick.
REQ-007 SHALL have port start_btn  in  1  start button, already synchronised and debounced, level.
REQ-008 SHALL have port level_sw  in  2  difficulty switch, sampled at game start only.
REQ-009 SHALL have port ball_lost  in  1  one-cycle pulse from the game core when the ball misses the bar.
REQ-010 SHALL have port brick_hit  in  1  one-cycle pulse from the game core on each brick bounce.
REQ-011 SHALL have port core_rst  out  1  active-high reset to the game core (ball/bar re-centre).
REQ-012 SHALL have port core_run  out  1  run enable to the game core (its start input).
REQ-013 SHALL have port bar_sel  out  2  latched difficulty, driving the core's bar-size select.
REQ-014 SHALL have port lives  out  2  remaining lives.
REQ-015 SHALL have port score  out  8  brick-hit count.
REQ-016 SHALL have port game_over  out  1  high while in OVER.
REQ-017 SHALL have port state  out  3  current FSM state, for debug/overlay.

Function
REQ-018 SHALL implement the FSM states IDLE=0, SERVE=1, PLAY=2, LOST=3 and OVER=4; codes 5-7 SHALL go to IDLE on the next clock.
REQ-019 SHALL detect a start_btn rising edge as start_btn=1 with its previous-cycle value 0, using one internal register.
REQ-020 IDLE: core_rst=1, core_run=0; on a start edge, next cycle SHALL enter SERVE with lives=LIVES, score=0, bar_sel=level_sw.
REQ-021 SERVE: core_rst=0, core_run=0; the frame counter SHALL clear on entry, increment per frame_tick, and enter PLAY on the tick that makes it equal SERVE_FRAMES.
REQ-022 PLAY: core_rst=0, core_run=1; each brick_hit pulse SHALL increment score, saturating at 255.
REQ-023 PLAY: a ball_lost pulse SHALL enter LOST next cycle; a brick_hit in the same cycle SHALL still be counted.
REQ-024 LOST SHALL last exactly one cycle: core_rst=1, core_run=0, and lives SHALL decrement by 1.
REQ-025 LOST: if lives was 1 on entry, SHALL enter OVER with lives=0; otherwise SHALL enter SERVE.
REQ-026 OVER: core_rst=0 and core_run=0, freezing the final picture; game_over=1; score SHALL be held.
REQ-027 OVER: the counter SHALL count frame_ticks and enter IDLE on the tick that makes it equal OVER_FRAMES.
REQ-028 Start edges SHALL be ignored outside IDLE; brick_hit and ball_lost SHALL be ignored outside PLAY.
REQ-029 level_sw changes after game start SHALL NOT affect bar_sel until the next IDLE->SERVE transition.
REQ-030 All outputs SHALL be registered; state-dependent outputs SHALL be valid in the first cycle of the state.

Reset
REQ-031 Reset low SHALL asynchronously force IDLE, core_rst=1, core_run=0, bar_sel=0, lives=0, score=0, game_over=0, counter=0 and edge register=0.
REQ-032 Reset asserted mid-game SHALL abandon the game; after release the block SHALL wait in IDLE for a new start edge, and a button held through release SHALL NOT start a game.

Structure
REQ-033 State encodings, LIVES default, and score/counter widths SHALL live in shared package game_pkg.
REQ-034 The frame counter SHALL be sub-module game_frame_timer (clear, tick, 8-bit terminal count in; done pulse out), used for both SERVE and OVER.

Verification
REQ-035 Reset, start pulse, level_sw=2 -> SERVE next cycle, lives=3, bar_sel=2; core_run rises on the 60th frame_tick.
REQ-036 PLAY, 3 brick_hit pulses -> score=3; 300 hits -> score=255, no wrap.
REQ-037 PLAY, ball_lost and brick_hit in the same cycle -> score+1, one LOST cycle with core_rst=1, lives 3->2, then SERVE.
REQ-038 Three losses -> OVER with lives=0, game_over=1 for 180 frame_ticks, then IDLE with core_rst=1.
REQ-039 Reset pulsed mid-PLAY with start_btn held high -> IDLE, all outputs at reset values, no restart until the button is released and pressed again.
